// File: rtl/pc_run_ctrl_if.sv
// Control bundle between the pipeline/board logic and the PC run/halt controller.
// Latency: none (wires only).
// Backpressure: none; the slave answers with a combinational PC write enable.
interface pc_run_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32,
    parameter int STEP_W  = 8
);
    logic [NUM_SRC-1:0] halt_req;
    logic [NUM_SRC-1:0] halt_mask;
    logic               go;
    logic               step_mode;
    logic [STEP_W-1:0]  step_len;
    logic               cnt_clr;
    logic               pc_enable;
    logic               halted;
    logic [NUM_SRC-1:0] halt_cause;
    logic               step_done;
    logic [CNT_W-1:0]   halt_count;
    logic [CNT_W-1:0]   run_cycles;

    // Requester side: pipeline, exception logic and board controls.
    modport master (
        output halt_req, halt_mask, go, step_mode, step_len, cnt_clr,
        input  pc_enable, halted, halt_cause, step_done, halt_count, run_cycles
    );

    // Controller side.
    modport slave (
        input  halt_req, halt_mask, go, step_mode, step_len, cnt_clr,
        output pc_enable, halted, halt_cause, step_done, halt_count, run_cycles
    );
endinterface

// File: rtl/pc_run_ctrl.sv
// PC run/halt controller: maskable halt sources, go-resume with grace cycle, bounded single-step, statistics.
// Latency: pc_enable drops in the same cycle a request is seen; halted/step_done/halt_cause update one edge later.
// Backpressure: the PC is frozen by pc_enable=0; go is only consumed while halted, so a held go acts as one pulse.
module pc_run_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32,
    parameter int STEP_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_run_ctrl_if.slave ctl
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STEP = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grace_q, grace_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;
    logic               step_done_q, step_done_d;
    logic [CNT_W-1:0]   halt_count_q;
    logic [CNT_W-1:0]   run_cycles_q;

    logic [NUM_SRC-1:0] eff_req;
    logic               hit;
    logic               pc_en;
    logic               halt_evt;

    // Effective requests and the zero-latency freeze; the grace cycle lets the frozen instruction advance.
    always_comb begin
        eff_req = ctl.halt_req & ~ctl.halt_mask;
        hit     = (state_q != HALT) && (|eff_req) && !grace_q;
        pc_en   = (state_q != HALT) && !hit;
    end

    // Next-state logic: request halts, step expiry and go-resume.
    always_comb begin
        state_d     = state_q;
        grace_d     = 1'b0;
        step_cnt_d  = step_cnt_q;
        cause_d     = cause_q;
        step_done_d = 1'b0;
        halt_evt    = 1'b0;
        case (state_q)
            RUN: begin
                if (hit) begin
                    state_d  = HALT;
                    cause_d  = eff_req;
                    halt_evt = 1'b1;
                end
            end
            STEP: begin
                if (hit) begin
                    // A real request wins over burst expiry.
                    state_d  = HALT;
                    cause_d  = eff_req;
                    halt_evt = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                    if (step_cnt_q <= STEP_W'(1)) begin
                        state_d     = HALT;
                        step_done_d = 1'b1;
                    end
                end
            end
            HALT: begin
                if (ctl.go) begin
                    grace_d = 1'b1;
                    if (ctl.step_mode) begin
                        state_d    = STEP;
                        step_cnt_d = (ctl.step_len == '0) ? STEP_W'(1) : ctl.step_len;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            grace_q     <= 1'b0;
            step_cnt_q  <= '0;
            cause_q     <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grace_q     <= grace_d;
            step_cnt_q  <= step_cnt_d;
            cause_q     <= cause_d;
            step_done_q <= step_done_d;
        end
    end

    // Statistics: halt count saturates, run cycles wrap, clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_count_q <= '0;
            run_cycles_q <= '0;
        end else if (ctl.cnt_clr) begin
            halt_count_q <= '0;
            run_cycles_q <= '0;
        end else begin
            if (halt_evt && (halt_count_q != '1)) begin
                halt_count_q <= halt_count_q + CNT_W'(1);
            end
            if (pc_en) begin
                run_cycles_q <= run_cycles_q + CNT_W'(1);
            end
        end
    end

    assign ctl.pc_enable  = pc_en;
    assign ctl.halted     = (state_q == HALT);
    assign ctl.halt_cause = cause_q;
    assign ctl.step_done  = step_done_q;
    assign ctl.halt_count = halt_count_q;
    assign ctl.run_cycles = run_cycles_q;
endmodule

// File: tb/tb_pc_run_ctrl.sv
// Directed vector bench for pc_run_ctrl; narrow counters expose saturation and wrap.
// Latency: checks pc_enable mid-cycle, registered outputs 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_pc_run_ctrl;
    localparam int NS = 4;
    localparam int CW = 4;
    localparam int SW = 8;

    typedef struct {
        logic [NS-1:0] req;
        logic [NS-1:0] mask;
        logic          go;
        logic          sm;
        logic [SW-1:0] sl;
        logic          clr;
        logic          pe;
        logic          h;
        logic [NS-1:0] cause;
        logic          sd;
        logic [CW-1:0] hc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [CW-1:0] exp_run = '0;
    vec_t tbl[$];

    pc_run_ctrl_if #(.NUM_SRC(NS), .CNT_W(CW), .STEP_W(SW)) bus();

    pc_run_ctrl #(.NUM_SRC(NS), .CNT_W(CW), .STEP_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [NS-1:0] req, input logic [NS-1:0] mask,
                                input logic go, input logic sm, input logic [SW-1:0] sl,
                                input logic clr, input logic pe, input logic h,
                                input logic [NS-1:0] cause, input logic sd, input logic [CW-1:0] hc);
        vec_t v;
        v.req = req; v.mask = mask; v.go = go; v.sm = sm; v.sl = sl; v.clr = clr;
        v.pe = pe; v.h = h; v.cause = cause; v.sd = sd; v.hc = hc;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check the comb enable, clock, check registered state.
    task automatic apply(input vec_t v, input int idx);
        bus.halt_req  = v.req;
        bus.halt_mask = v.mask;
        bus.go        = v.go;
        bus.step_mode = v.sm;
        bus.step_len  = v.sl;
        bus.cnt_clr   = v.clr;
        #3;
        check("pc_enable", idx, 32'(bus.pc_enable), 32'(v.pe));
        @(posedge clk);
        #1;
        exp_run = v.clr ? '0 : exp_run + CW'(v.pe);
        check("halted", idx, 32'(bus.halted), 32'(v.h));
        check("halt_cause", idx, 32'(bus.halt_cause), 32'(v.cause));
        check("step_done", idx, 32'(bus.step_done), 32'(v.sd));
        check("halt_count", idx, 32'(bus.halt_count), 32'(v.hc));
        check("run_cycles", idx, 32'(bus.run_cycles), 32'(exp_run));
        n_vec++;
    endtask

    initial begin
        logic [CW-1:0] hc;
        logic [NS-1:0] cs;

        // Idle run: ten free-running cycles.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 8'd0, 0, 1, 0, 4'b0000, 0, 4'd0));
        // Syscall halt, go with request still high, grace cycle, re-halt.
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 0, 1, 4'b0001, 0, 4'd1));
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 0, 1, 4'b0001, 0, 4'd1));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 8'd0, 0, 0, 0, 4'b0001, 0, 4'd1));
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 1, 0, 4'b0001, 0, 4'd1));
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 0, 1, 4'b0001, 0, 4'd2));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 8'd0, 0, 0, 1, 4'b0001, 0, 4'd2));
        // Resume with go held two cycles, then masked sources.
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 8'd0, 0, 0, 0, 4'b0001, 0, 4'd2));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 8'd0, 0, 1, 0, 4'b0001, 0, 4'd2));
        tbl.push_back(mk(4'b0011, 4'b0001, 0, 0, 8'd0, 0, 0, 1, 4'b0010, 0, 4'd3));
        tbl.push_back(mk(4'b0000, 4'b0001, 1, 0, 8'd0, 0, 0, 0, 4'b0010, 0, 4'd3));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 8'd0, 0, 1, 0, 4'b0010, 0, 4'd3));
        // Step burst of 3.
        tbl.push_back(mk(4'b0010, 4'b0001, 0, 0, 8'd0, 0, 0, 1, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 1, 8'd3, 0, 0, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd3, 0, 1, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd3, 0, 1, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd3, 0, 1, 1, 4'b0010, 1, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd3, 0, 0, 1, 4'b0010, 0, 4'd4));
        // Step length 0 behaves as 1.
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 1, 8'd0, 0, 0, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd0, 0, 1, 1, 4'b0010, 1, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd0, 0, 0, 1, 4'b0010, 0, 4'd4));
        // Request in cycle 2 of a 5-cycle burst.
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 1, 8'd5, 0, 0, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd5, 0, 1, 0, 4'b0010, 0, 4'd4));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 1, 8'd5, 0, 0, 1, 4'b0100, 0, 4'd5));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 8'd5, 0, 0, 1, 4'b0100, 0, 4'd5));
        // Clear in the same cycle as a halt.
        tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 8'd0, 0, 0, 0, 4'b0100, 0, 4'd5));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 8'd0, 0, 1, 0, 4'b0100, 0, 4'd5));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 8'd0, 1, 0, 1, 4'b1000, 0, 4'd0));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 8'd0, 0, 0, 1, 4'b1000, 0, 4'd0));

        bus.halt_req = '0; bus.halt_mask = '0; bus.go = 1'b0;
        bus.step_mode = 1'b0; bus.step_len = '0; bus.cnt_clr = 1'b0;

        // Reset state.
        #12;
        check("rst_pc_enable", -1, 32'(bus.pc_enable), 32'd1);
        check("rst_halted", -1, 32'(bus.halted), 32'd0);
        check("rst_halt_count", -1, 32'(bus.halt_count), 32'd0);
        check("rst_run_cycles", -1, 32'(bus.run_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
            if (i == 9) check("run_after_idle", i, 32'(bus.run_cycles), 32'd10);
        end

        // Repeated halts: count saturates at all-ones, run counter wraps.
        hc = '0;
        cs = 4'b1000;
        for (int i = 1; i <= 16; i++) begin
            apply(mk(4'b0000, 4'b0000, 1, 0, 8'd0, 0, 0, 0, cs, 0, hc), 100 + 3 * i);
            apply(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 1, 0, cs, 0, hc), 101 + 3 * i);
            hc = (hc == '1) ? hc : hc + CW'(1);
            cs = 4'b0001;
            apply(mk(4'b0001, 4'b0000, 0, 0, 8'd0, 0, 0, 1, cs, 0, hc), 102 + 3 * i);
        end
        check("sat_halt_count", 200, 32'(bus.halt_count), 32'hF);

        // Reset in the middle of a step burst.
        apply(mk(4'b0000, 4'b0000, 1, 1, 8'd5, 0, 0, 0, 4'b0001, 0, 4'd15), 300);
        apply(mk(4'b0000, 4'b0000, 0, 1, 8'd5, 0, 1, 0, 4'b0001, 0, 4'd15), 301);
        rst_n = 1'b0;
        #2;
        check("midrst_pc_enable", 302, 32'(bus.pc_enable), 32'd1);
        check("midrst_halted", 302, 32'(bus.halted), 32'd0);
        check("midrst_halt_count", 302, 32'(bus.halt_count), 32'd0);
        check("midrst_run_cycles", 302, 32'(bus.run_cycles), 32'd0);
        check("midrst_halt_cause", 302, 32'(bus.halt_cause), 32'd0);
        #2;
        rst_n = 1'b1;
        exp_run = '0;
        for (int i = 0; i < 6; i++) apply(mk(4'b0000, 4'b0000, 0, 1, 8'd5, 0, 1, 0, 4'b0000, 0, 4'd0), 310 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_run_ctrl.md
Name: pc_run_ctrl

Overview:
- Parametrised PC run/halt controller for the pipelined MIPS CPU.
- Generalises the single-syscall PC enable into NUM_SRC maskable halt sources, a go-resume with a one-cycle grace window, a single-step mode of programmable length, and halt/run statistics counters for the board display.
- Sits between decode/exception logic and the PC register, and drives the PC write enable.

Parameters:
- NUM_SRC, 4, number of independent halt request sources (bit 0 = syscall).
- CNT_W, 32, width of halt_count and run_cycles.
- STEP_W, 8, width of step_len.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halt_req  in  NUM_SRC  level halt requests from the pipeline.
- halt_mask  in  NUM_SRC  1 = ignore that source (display/show bypass).
- go  in  1  one-cycle resume pulse, already synchronised/debounced.
- step_mode  in  1  1 = go grants a bounded burst instead of a free run.
- step_len  in  STEP_W  cycles granted per step; 0 is treated as 1.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_enable  out  1  PC write enable.
- halted  out  1  1 while in HALT.
- halt_cause  out  NUM_SRC  effective sources latched at the last request-caused halt.
- step_done  out  1  one-cycle pulse when a step burst expires.
- halt_count  out  CNT_W  number of request-caused halts.
- run_cycles  out  CNT_W  cycles with pc_enable=1.

Behaviour:
- Definitions:
  - hit = |(halt_req & ~halt_mask) & ~grace.
  - grace is a 1-bit register, set for exactly the first cycle after leaving HALT, so the frozen halting instruction can advance.
- State register: RUN, STEP, HALT.
- Reset (rst_n=0, asynchronous): state=RUN, grace=0, step counter=0, halt_cause=0, step_done=0, halt_count=0, run_cycles=0.
  - Outputs during and after reset: pc_enable=1, halted=0.
  - Reset mid-step or mid-halt returns to RUN immediately.
- pc_enable is combinational:
  - 1 in RUN/STEP when hit=0.
  - 0 when hit=1, so the PC freezes on the same edge the request is seen (zero-cycle latency).
  - 0 in HALT.
- halted = (state==HALT), registered.
- RUN:
  - hit=1: next state HALT; halt_cause <= halt_req & ~halt_mask; halt_count++.
  - go: ignored.
- STEP:
  - Counter loads max(step_len,1) on entry.
  - Each cycle with pc_enable=1 decrements the counter.
  - When the counter is 1 and hit=0: next state HALT; step_done=1 for one cycle; halt_cause and halt_count unchanged.
  - hit=1 takes priority over expiry: same update as in RUN (cause latched, count++, no step_done).
- HALT:
  - go=1 and step_mode=0: next state RUN.
  - go=1 and step_mode=1: next state STEP.
  - In both cases grace<=1; halt_cause holds its value until the next request-caused halt.
  - halt_req changes while halted have no effect.
  - step_mode is sampled only on the go edge.
- Grace cycle: the requester still asserting in that cycle does not re-halt. A request still asserted in the following cycle halts again.
- step_len=1 with no requests: exactly one cycle of pc_enable=1 per go.
- Counters:
  - halt_count saturates at all-ones.
  - run_cycles wraps modulo 2^CNT_W.
  - cnt_clr has priority over increment in the same cycle and does not affect state.
- go width: a go held high for several cycles acts as one pulse, since only HALT consumes it. After a step burst ends, go must be deasserted and reasserted.

Test Plan:
- Reset, then idle 10 cycles -> pc_enable=1 throughout, halted=0, run_cycles=10, halt_count=0.
- halt_req=4'b0001 held from cycle 5 -> pc_enable=0 in cycle 5; halted=1 from cycle 6; halt_cause=4'b0001; halt_count=1.
  - Then go pulse with halt_req still high -> one grace cycle with pc_enable=1, re-halt the next cycle, halt_count=2.
- halt_mask=4'b0001, halt_req=4'b0011 -> halt with halt_cause=4'b0010. With halt_req=4'b0001 only -> no halt.
- step_mode=1, step_len=3, go from HALT, no requests -> pc_enable=1 for exactly 3 cycles; step_done pulses on the third; halted=1 after; run_cycles +3.
- step_len=0 -> 1-cycle burst. A request in cycle 2 of a step_len=5 burst -> halt with cause latched, no step_done, halt_count+1.
- rst_n low mid-STEP -> immediate pc_enable=1, counters 0.
  - Also: cnt_clr together with a halt in the same cycle -> halt_count=0.
  - Also: preload halt_count=all-ones, then another halt -> stays all-ones.
